// File: rtl/aclock_set_ctrl.sv
// Time/alarm setting controller: synchronizes and debounces four buttons, runs the
// hour/minute edit FSM and pulses the load strobe towards the clock core on commit.
module aclock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LD_HOLD         = 10,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_t,
  input  logic       btn_set_a,
  input  logic       btn_inc,
  input  logic       btn_next,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [1:0] edit_field,
  output logic       edit_target
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EDIT_H = 2'b01,
    EDIT_M = 2'b10,
    COMMIT = 2'b11
  } state_e;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW  = $clog2(LD_HOLD + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LD_HOLD - 1);

  logic [3:0] btnRaw;
  logic [3:0] btnEvt;
  logic       evSetT, evSetA, evInc, evNext;

  assign btnRaw = {btn_next, btn_inc, btn_set_a, btn_set_t};

  // Per button: 2-flop synchronizer, then a level that only flips after the synchronized
  // value has disagreed with it for DEBOUNCE_CYCLES cycles in a row; the flip to 1 emits one event.
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic           sync1_q, sync2_q, level_q, evt_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        evt_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btnRaw[i];
        sync2_q <= sync1_q;
        evt_q   <= 1'b0;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          level_q <= sync2_q;
          evt_q   <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign btnEvt[i] = evt_q;
  end

  assign evSetT = btnEvt[0];
  assign evSetA = btnEvt[1];
  assign evInc  = btnEvt[2];
  assign evNext = btnEvt[3];

  state_e        state_q, state_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    minute_q, minute_d;
  logic          target_q, target_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hour_q   <= '0;
      minute_q <= '0;
      target_q <= 1'b0;
      tmo_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      target_q <= target_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
    end
  end

  // next beats inc in the same cycle; any inc/next restarts the idle timeout
  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    target_d = target_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        tmo_d  = '0;
        hold_d = '0;
        if (evSetT) begin
          state_d  = EDIT_H;
          target_d = 1'b0;
        end else if (evSetA) begin
          state_d  = EDIT_H;
          target_d = 1'b1;
        end
      end
      EDIT_H: begin
        if (evNext) begin
          state_d = EDIT_M;
          tmo_d   = '0;
        end else if (evInc) begin
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          tmo_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      EDIT_M: begin
        if (evNext) begin
          state_d = COMMIT;
          tmo_d   = '0;
          hold_d  = '0;
        end else if (evInc) begin
          minute_d = (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COMMIT: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BCD split by range; the units subtract only needs 4 bits since (tens*10) mod 16 is the offset
  always_comb begin
    H_in1 = 2'd0;
    H_in0 = hour_q[3:0];
    if (hour_q >= 5'd20) begin
      H_in1 = 2'd2;
      H_in0 = hour_q[3:0] - 4'd4;
    end else if (hour_q >= 5'd10) begin
      H_in1 = 2'd1;
      H_in0 = hour_q[3:0] - 4'd10;
    end
  end

  always_comb begin
    M_in1 = 4'd0;
    M_in0 = minute_q[3:0];
    if (minute_q >= 6'd50) begin
      M_in1 = 4'd5;
      M_in0 = minute_q[3:0] - 4'd2;
    end else if (minute_q >= 6'd40) begin
      M_in1 = 4'd4;
      M_in0 = minute_q[3:0] - 4'd8;
    end else if (minute_q >= 6'd30) begin
      M_in1 = 4'd3;
      M_in0 = minute_q[3:0] - 4'd14;
    end else if (minute_q >= 6'd20) begin
      M_in1 = 4'd2;
      M_in0 = minute_q[3:0] - 4'd4;
    end else if (minute_q >= 6'd10) begin
      M_in1 = 4'd1;
      M_in0 = minute_q[3:0] - 4'd10;
    end
  end

  assign LD_time     = (state_q == COMMIT) && !target_q;
  assign LD_alarm    = (state_q == COMMIT) && target_q;
  assign edit_field  = state_q;
  assign edit_target = target_q;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Self-checking bench for aclock_set_ctrl: scenario tasks drive buttons and check inline,
// a negedge monitor pops expected state transitions and strobe lengths from scoreboard queues.
module tb_aclock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_set_t, btn_set_a, btn_inc, btn_next;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm;
  logic [1:0] edit_field;
  logic       edit_target;

  int numChecks = 0;
  int numBad    = 0;

  logic [1:0] fieldQ[$];
  int         timeQ[$];
  int         alarmQ[$];

  aclock_set_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn_set_t  (btn_set_t),
    .btn_set_a  (btn_set_a),
    .btn_inc    (btn_inc),
    .btn_next   (btn_next),
    .H_in1      (H_in1),
    .H_in0      (H_in0),
    .M_in1      (M_in1),
    .M_in0      (M_in0),
    .LD_time    (LD_time),
    .LD_alarm   (LD_alarm),
    .edit_field (edit_field),
    .edit_target(edit_target)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every state change and every finished strobe pulse is matched
  // against what the scenario pushed; reset clears the tracking without comparing.
  logic [1:0] prevField = 2'b00;
  int         strobeLen = 0;
  logic       strobeIsAlarm = 1'b0;
  always @(negedge clk) begin
    logic [1:0] expField;
    int         expLen;
    if (reset !== 1'b1) begin
      prevField = 2'b00;
      strobeLen = 0;
    end else begin
      if (edit_field !== prevField) begin
        numChecks++;
        if (fieldQ.size() == 0) begin
          numBad++;
          $display("[TB] FAIL field_seq: got %b, no transition expected", edit_field);
        end else begin
          expField = fieldQ.pop_front();
          if (edit_field !== expField) begin
            numBad++;
            $display("[TB] FAIL field_seq: got %b, expected %b", edit_field, expField);
          end
        end
        prevField = edit_field;
      end
      if (LD_time || LD_alarm) begin
        numChecks++;
        if (LD_time && LD_alarm) begin
          numBad++;
          $display("[TB] FAIL strobe_excl: LD_time=%b LD_alarm=%b, expected not both", LD_time, LD_alarm);
        end
        if (strobeLen == 0) strobeIsAlarm = LD_alarm;
        strobeLen++;
      end else if (strobeLen != 0) begin
        numChecks++;
        if (strobeIsAlarm ? (alarmQ.size() == 0) : (timeQ.size() == 0)) begin
          numBad++;
          $display("[TB] FAIL strobe_len: unexpected %s pulse of %0d cycles",
                   strobeIsAlarm ? "LD_alarm" : "LD_time", strobeLen);
        end else begin
          expLen = strobeIsAlarm ? alarmQ.pop_front() : timeQ.pop_front();
          if (strobeLen != expLen) begin
            numBad++;
            $display("[TB] FAIL strobe_len: %s high %0d cycles, expected %0d",
                     strobeIsAlarm ? "LD_alarm" : "LD_time", strobeLen, expLen);
          end
        end
        strobeLen = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, total=%0d bad=%0d", numChecks, numBad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Holds the given buttons {next,inc,set_a,set_t} long enough to debounce, then releases.
  task automatic applyStimulus(input logic [3:0] m);
    {btn_next, btn_inc, btn_set_a, btn_set_t} = m;
    repeat (8) @(negedge clk);
    {btn_next, btn_inc, btn_set_a, btn_set_t} = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {btn_next, btn_inc, btn_set_a, btn_set_t} = 4'b0000;
    repeat (3) @(negedge clk);
    numChecks++;
    if (edit_field !== 2'b00) begin numBad++; $display("[TB] FAIL reset_field: got %b, expected 00", edit_field); end
    numChecks++;
    if ({LD_time, LD_alarm, edit_target} !== 3'b000) begin
      numBad++; $display("[TB] FAIL reset_flags: got %b, expected 000", {LD_time, LD_alarm, edit_target});
    end
    numChecks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
      numBad++; $display("[TB] FAIL reset_digits: got %h, expected 0", {H_in1, H_in0, M_in1, M_in0});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hour_set();
    fieldQ.push_back(2'b01);
    applyStimulus(4'b0001);
    numChecks++;
    if (edit_target !== 1'b0) begin numBad++; $display("[TB] FAIL hour_target: got %b, expected 0", edit_target); end
    for (int i = 0; i < 25; i++) applyStimulus(4'b0100);
    numChecks++;
    if ({H_in1, H_in0} !== {2'd0, 4'd1}) begin
      numBad++; $display("[TB] FAIL hour_wrap: got %0d%0d, expected 01", H_in1, H_in0);
    end
    fieldQ.push_back(2'b10);
    applyStimulus(4'b1000);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100);
    fieldQ.push_back(2'b11);
    fieldQ.push_back(2'b00);
    timeQ.push_back(10);
    applyStimulus(4'b1000);
    repeat (4) @(negedge clk);
    numChecks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== {2'd0, 4'd1, 4'd0, 4'd3}) begin
      numBad++; $display("[TB] FAIL hour_commit_val: got %0d%0d:%0d%0d, expected 01:03", H_in1, H_in0, M_in1, M_in0);
    end
    numChecks++;
    if (edit_field !== 2'b00) begin numBad++; $display("[TB] FAIL hour_idle: got %b, expected 00", edit_field); end
  endtask

  task automatic test_alarm_minute_wrap();
    doReset();
    fieldQ.push_back(2'b01);
    applyStimulus(4'b0010);
    numChecks++;
    if (edit_target !== 1'b1) begin numBad++; $display("[TB] FAIL alarm_target: got %b, expected 1", edit_target); end
    fieldQ.push_back(2'b10);
    applyStimulus(4'b1000);
    for (int i = 0; i < 61; i++) applyStimulus(4'b0100);
    numChecks++;
    if ({M_in1, M_in0} !== {4'd0, 4'd1}) begin
      numBad++; $display("[TB] FAIL minute_wrap: got %0d%0d, expected 01", M_in1, M_in0);
    end
    fieldQ.push_back(2'b11);
    fieldQ.push_back(2'b00);
    alarmQ.push_back(10);
    applyStimulus(4'b1000);
    repeat (4) @(negedge clk);
    numChecks++;
    if ({edit_target, H_in1, H_in0} !== {1'b1, 2'd0, 4'd0}) begin
      numBad++; $display("[TB] FAIL alarm_after: target=%b H=%0d%0d, expected target=1 H=00", edit_target, H_in1, H_in0);
    end
  endtask

  task automatic test_bounce();
    fieldQ.push_back(2'b01);
    applyStimulus(4'b0001);
    btn_inc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_inc = ~btn_inc;
      @(negedge clk);
    end
    btn_inc = 1'b1;
    repeat (6) @(negedge clk);
    numChecks++;
    if ({H_in1, H_in0} !== {2'd0, 4'd0}) begin
      numBad++; $display("[TB] FAIL bounce_early: got H=%0d%0d, expected 00", H_in1, H_in0);
    end
    @(negedge clk);
    numChecks++;
    if ({H_in1, H_in0} !== {2'd0, 4'd1}) begin
      numBad++; $display("[TB] FAIL bounce_inc: got H=%0d%0d, expected 01", H_in1, H_in0);
    end
    repeat (20) @(negedge clk);
    numChecks++;
    if ({H_in1, H_in0} !== {2'd0, 4'd1}) begin
      numBad++; $display("[TB] FAIL bounce_held: got H=%0d%0d, expected 01", H_in1, H_in0);
    end
    btn_inc = 1'b0;
    fieldQ.push_back(2'b00);
    repeat (88) @(negedge clk);
  endtask

  task automatic test_timeout();
    doReset();
    fieldQ.push_back(2'b01);
    applyStimulus(4'b0001);
    applyStimulus(4'b0100);
    fieldQ.push_back(2'b00);
    repeat (40) @(negedge clk);
    numChecks++;
    if (edit_field !== 2'b01) begin numBad++; $display("[TB] FAIL timeout_early: got %b, expected 01", edit_field); end
    repeat (30) @(negedge clk);
    numChecks++;
    if (edit_field !== 2'b00) begin numBad++; $display("[TB] FAIL timeout_idle: got %b, expected 00", edit_field); end
    numChecks++;
    if ({H_in1, H_in0} !== {2'd0, 4'd1}) begin
      numBad++; $display("[TB] FAIL timeout_keep: got H=%0d%0d, expected 01", H_in1, H_in0);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    logic seen;
    fieldQ.push_back(2'b01);
    applyStimulus(4'b0001);
    fieldQ.push_back(2'b10);
    applyStimulus(4'b1100);
    numChecks++;
    if ({edit_field, H_in1, H_in0, M_in1, M_in0} !== {2'b10, 2'd0, 4'd1, 4'd0, 4'd0}) begin
      numBad++; $display("[TB] FAIL simul_inc_next: field=%b H=%0d%0d M=%0d%0d, expected 10 01 00",
                         edit_field, H_in1, H_in0, M_in1, M_in0);
    end
    fieldQ.push_back(2'b11);
    btn_next = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (edit_field === 2'b11) seen = 1'b1;
    end
    numChecks++;
    if (!seen) begin numBad++; $display("[TB] FAIL commit_reach: got %b, expected 11 within 30 cycles", edit_field); end
    repeat (2) @(negedge clk);
    numChecks++;
    if (LD_time !== 1'b1) begin numBad++; $display("[TB] FAIL commit_cyc3: LD_time=%b, expected 1", LD_time); end
    #2;
    reset = 1'b0;
    btn_next = 1'b0;
    #1;
    numChecks++;
    if ({LD_time, LD_alarm, edit_field, edit_target} !== 5'b00000) begin
      numBad++; $display("[TB] FAIL midreset_ctrl: got %b, expected 00000", {LD_time, LD_alarm, edit_field, edit_target});
    end
    numChecks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
      numBad++; $display("[TB] FAIL midreset_digits: got %h, expected 0", {H_in1, H_in0, M_in1, M_in0});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    numChecks++;
    if (edit_field !== 2'b00) begin numBad++; $display("[TB] FAIL post_reset_idle: got %b, expected 00", edit_field); end
  endtask

  initial begin
    test_reset();
    test_hour_set();
    test_alarm_minute_wrap();
    test_bounce();
    test_timeout();
    test_simultaneous_and_reset();
    numChecks++;
    if (fieldQ.size() != 0 || timeQ.size() != 0 || alarmQ.size() != 0) begin
      numBad++;
      $display("[TB] FAIL scoreboard_drain: left field=%0d time=%0d alarm=%0d, expected 0 0 0",
               fieldQ.size(), timeQ.size(), alarmQ.size());
    end
    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule
